pipe_stage_reg: RTL and testbench

// - Generic parametrised pipeline stage register for the 64-bit datapath, replacing the fixed per-stage registers.
// - Carries a one-hot control bundle, a data payload and a destination register index with valid/ready handshake, stall and flush.
// - Drops in between any two stages (ID/EX, EX/M, M/WB); a combinational pass-through lane carries late synchronous-memory read data.

---
 rtl/pipe_stage_reg.sv | 134 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline stage register with valid/ready, stall, flush and pass-through lane
// Optional 2-entry skid buffer selected by PIPE_STAGE_SKID_EN.
module pipe_stage_reg #(
    parameter int CTRL_W     = 6,
    parameter int DATA_W     = 256,
    parameter int DEST_IN_W  = 5,
    parameter int DEST_OUT_W = 3,
    parameter int PASS_W     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic                  in_wre,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [DEST_IN_W-1:0]  in_dest,
    input  logic [PASS_W-1:0]     pass_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic                  out_wre,
    output logic [DATA_W-1:0]     out_data,
    output logic [DEST_OUT_W-1:0] out_dest,
    output logic [PASS_W-1:0]     pass_out,
    output logic [1:0]            occupancy
);

    logic                  r_valid;
    logic [CTRL_W-1:0]     r_ctrl;
    logic                  r_wre;
    logic [DATA_W-1:0]     r_data;
    logic [DEST_OUT_W-1:0] r_dest;
    logic                  w_in_fire;
    logic [DEST_OUT_W-1:0] w_dest_trunc;

    assign w_dest_trunc = in_dest[DEST_OUT_W-1:0];
    assign w_in_fire    = in_valid & in_ready;

    // Bubbles must never reach the register file, so ctrl/wre are gated.
    assign out_valid = r_valid;
    assign out_ctrl  = r_ctrl & {CTRL_W{r_valid}};
    assign out_wre   = r_wre & r_valid;
    assign out_data  = r_data;
    assign out_dest  = r_dest;
    assign pass_out  = pass_in;

`ifdef PIPE_STAGE_SKID_EN
    logic                  r_s_valid;
    logic [CTRL_W-1:0]     r_s_ctrl;
    logic                  r_s_wre;
    logic [DATA_W-1:0]     r_s_data;
    logic [DEST_OUT_W-1:0] r_s_dest;

    assign in_ready  = !r_s_valid;
    assign occupancy = {r_valid & r_s_valid, r_valid ^ r_s_valid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_wre     <= 1'b0;
            r_data    <= '0;
            r_dest    <= '0;
            r_s_valid <= 1'b0;
            r_s_ctrl  <= '0;
            r_s_wre   <= 1'b0;
            r_s_data  <= '0;
            r_s_dest  <= '0;
        end else if (flush) begin
            r_valid   <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (!r_valid) begin
            // Skid is never occupied while main is empty.
            if (w_in_fire) begin
                r_valid <= 1'b1;
                r_ctrl  <= in_ctrl;
                r_wre   <= in_wre;
                r_data  <= in_data;
                r_dest  <= w_dest_trunc;
            end
        end else if (out_ready) begin
            if (r_s_valid) begin
                r_ctrl    <= r_s_ctrl;
                r_wre     <= r_s_wre;
                r_data    <= r_s_data;
                r_dest    <= r_s_dest;
                r_s_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_ctrl <= in_ctrl;
                r_wre  <= in_wre;
                r_data <= in_data;
                r_dest <= w_dest_trunc;
            end else begin
                r_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_s_valid <= 1'b1;
            r_s_ctrl  <= in_ctrl;
            r_s_wre   <= in_wre;
            r_s_data  <= in_data;
            r_s_dest  <= w_dest_trunc;
        end
    end
`else
    logic w_out_fire;

    assign in_ready   = !r_valid | out_ready;
    assign w_out_fire = r_valid & out_ready;
    assign occupancy  = {1'b0, r_valid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_wre   <= 1'b0;
            r_data  <= '0;
            r_dest  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_ctrl  <= in_ctrl;
            r_wre   <= in_wre;
            r_data  <= in_data;
            r_dest  <= w_dest_trunc;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   in_ctrl;
    logic         in_wre;
    logic [255:0] in_data;
    logic [4:0]   in_dest;
    logic [63:0]  pass_in;
    logic         out_valid;
    logic         out_ready;
    logic [5:0]   out_ctrl;
    logic         out_wre;
    logic [255:0] out_data;
    logic [2:0]   out_dest;
    logic [63:0]  pass_out;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_wre    (in_wre),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .pass_in   (pass_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_wre   (out_wre),
        .out_data  (out_data),
        .out_dest  (out_dest),
        .pass_out  (pass_out),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_wre = 1'b0;
        in_data = '0; in_dest = 5'b11101; pass_in = 64'h1234; out_ready = 1'b0;
        #1;
        check("rst_pass_out", pass_out, 64'h1234);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_out_data", out_data, 256'd0);
        check("rst_out_ctrl", out_ctrl, 6'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // stream of four beats
        out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 6'b000010; in_wre = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 256'(i);
            tick();
            check("stream_data", out_data, 256'(i));
            check("stream_valid", out_valid, 1'b1);
            check("stream_occ", occupancy, 2'd1);
        end
        check("trunc_dest", out_dest, 3'b101);
        check("stream_ctrl", out_ctrl, 6'b000010);
        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 1'b0);
        check("drain_wre", out_wre, 1'b0);
        check("drain_data_held", out_data, 256'd4);

        // stall with 0xAA held, 0xBB waiting
        out_ready = 1'b0; in_valid = 1'b1; in_data = 256'hAA;
        tick();
        check("stall_load", out_data, 256'hAA);
        in_data = 256'hBB;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        check("stall_in_ready_skid", in_ready, 1'b1);
`else
        check("stall_in_ready_base", in_ready, 1'b0);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_data", out_data, 256'hAA);
            check("stall_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
            check("stall_occ", occupancy, 2'd2);
`else
            check("stall_occ", occupancy, 2'd1);
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        in_valid = 1'b0;
`endif
        out_ready = 1'b1;
        tick();
        check("unstall_data", out_data, 256'hBB);
        check("unstall_valid", out_valid, 1'b1);
        check("unstall_occ", occupancy, 2'd1);
        in_valid = 1'b0;
        tick();
        check("unstall_drain", out_valid, 1'b0);
        check("unstall_drain_occ", occupancy, 2'd0);

        // flush a held entry
        out_ready = 1'b0; in_valid = 1'b1; in_data = 256'h99;
        tick();
        check("flush_pre_valid", out_valid, 1'b1);
        in_valid = 1'b0; flush = 1'b1;
        tick();
        check("flush_held_valid", out_valid, 1'b0);
        check("flush_held_occ", occupancy, 2'd0);
        check("flush_held_data", out_data, 256'h99);

        // flush against an in fire
        out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 6'b000010; in_wre = 1'b1; in_data = 256'hCC;
        #1;
        check("flush_fire_in_ready", in_ready, 1'b1);
        tick();
        check("flush_fire_valid", out_valid, 1'b0);
        check("flush_fire_wre", out_wre, 1'b0);
        check("flush_fire_ctrl", out_ctrl, 6'd0);
        check("flush_fire_occ", occupancy, 2'd0);
        flush = 1'b0;

        // bubble gating
        in_ctrl = 6'b000100; in_wre = 1'b1; in_data = 256'h55;
        tick();
        check("bubble_beat_ctrl", out_ctrl, 6'b000100);
        check("bubble_beat_wre", out_wre, 1'b1);
        in_valid = 1'b0;
        tick();
        check("bubble_ctrl", out_ctrl, 6'd0);
        check("bubble_wre", out_wre, 1'b0);
        check("bubble_data", out_data, 256'h55);

        pass_in = 64'hBEEF;
        #1;
        check("pass_same_cycle", pass_out, 64'hBEEF);

        // asynchronous reset mid-stream
        in_valid = 1'b1; in_data = 256'h77;
        tick();
        check("midrst_pre_valid", out_valid, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_ctrl", out_ctrl, 6'd0);
        check("midrst_data", out_data, 256'd0);
        check("midrst_occ", occupancy, 2'd0);
        check("midrst_pass", pass_out, 64'hBEEF);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
